// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and widths for the serial transmitter
`timescale 1ns/1ps
package serial_tx_pkg;
    localparam int DATA_W    = 8;
    localparam int BIT_CNT_W = 3;
    // Prefixed names keep the enum clear of the DATA port identifier.
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
endpackage

// File: rtl/serial_tx_baud.sv
// serial_tx_baud: bit-period counter producing one tick per serial bit
// Ports: clk_i clock, rst_i async active-high reset, en_i count enable
//        (counter held at 0 when low), tick_o high on the last cycle of a bit.
`timescale 1ns/1ps
module serial_tx_baud #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;
    assign last   = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign tick_o = en_i && last;
    assign cnt_d  = (!en_i || last) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter with SEND/DONE handshake
// Ports: CLK_TX clock, RST async active-high reset, DATA byte latched at frame
//        start, SEND level request (needs a low level to re-arm), TX serial line
//        (idle high, registered), DONE one-cycle pulse at frame completion.
`timescale 1ns/1ps
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic              CLK_TX,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA,
    input  logic              SEND,
    output logic              TX,
    output logic              DONE
);
    state_t                 state_q, state_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   armed_q, armed_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic                   tick;

    serial_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i (CLK_TX),
        .rst_i (RST),
        .en_i  (state_q != ST_IDLE),
        .tick_o(tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        armed_d    = armed_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!SEND) armed_d = 1'b1;
                else if (armed_q) begin
                    shift_d    = DATA;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    armed_d    = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: if (tick) state_d = ST_DATA;
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == '1) state_d = ST_STOP;
                    else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else stop_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // TX is decoded from next state so the line is registered with no input path.
        tx_d = state_d == ST_START ? 1'b0 : state_d == ST_DATA ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge CLK_TX or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            armed_q    <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            armed_q    <= armed_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign TX   = tx_q;
    assign DONE = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed self-checking bench for serial_tx
`timescale 1ns/1ps
module tb_serial_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       send_a = 1'b0, send_b = 1'b0;
    logic       tx_a, done_a, tx_b, done_b;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    serial_tx dut_a (
        .CLK_TX(clk), .RST(rst), .DATA(data_a), .SEND(send_a), .TX(tx_a), .DONE(done_a)
    );
    serial_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
        .CLK_TX(clk), .RST(rst), .DATA(data_b), .SEND(send_b), .TX(tx_b), .DONE(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        send_a = 1'b0;
        step();
    endtask

    // Raises SEND and records 10 TX samples (start..stop) plus 11 DONE samples,
    // first sample in the MSB so expected literals read in line order.
    task automatic capture(input logic [7:0] d, input int chg_at, input logic [7:0] chg_val,
                           output logic [9:0] bits, output logic [10:0] dones);
        data_a = d;
        send_a = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            if (i < 10) bits[9-i] = tx_a;
            dones[10-i] = done_a;
            if (i == chg_at) data_a = chg_val;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx_a got %b want 1", tx_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done_a got %b want 0", done_a); end
        checks++; if (tx_b !== 1'b1) begin errors++; $display("FAIL reset_tx_b got %b want 1", tx_b); end
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL reset_done_b got %b want 0", done_b); end
        rst = 1'b0;
    endtask

    task automatic test_frame();
        logic [9:0] bits;
        logic [10:0] dones;
        arm();
        capture(8'hD2, -1, 8'h00, bits, dones);
        checks++; if (bits !== 10'b0010010111) begin errors++; $display("FAIL frame_d2 bits got %b want %b", bits, 10'b0010010111); end
        checks++; if (dones !== 11'b00000000001) begin errors++; $display("FAIL frame_d2 done got %b want %b", dones, 11'b00000000001); end
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL frame_d2 idle_tx got %b want 1", tx_a); end
        step();
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL frame_d2 done_drop got %b want 0", done_a); end
    endtask

    task automatic test_send_held();
        logic [9:0] bits;
        logic [10:0] dones;
        int bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx_a !== 1'b1 || done_a !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL send_held bad_cycles got %0d want 0", bad); end
        arm();
        capture(8'h55, -1, 8'h00, bits, dones);
        checks++; if (bits !== 10'b0101010101) begin errors++; $display("FAIL frame_55 bits got %b want %b", bits, 10'b0101010101); end
        checks++; if (dones !== 11'b00000000001) begin errors++; $display("FAIL frame_55 done got %b want %b", dones, 11'b00000000001); end
    endtask

    task automatic test_slow();
        int bad = 0, done_idx = -1, done_cnt = 0;
        data_b = 8'h00;
        send_b = 1'b1;
        for (int i = 0; i < 46; i++) begin
            step();
            if (i < 44 && tx_b !== (i < 36 ? 1'b0 : 1'b1)) bad++;
            if (done_b === 1'b1) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
        end
        send_b = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL slow_tx bad_cycles got %0d want 0", bad); end
        checks++; if (done_idx != 44) begin errors++; $display("FAIL slow_done_at got %0d want 44", done_idx); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL slow_done_width got %0d want 1", done_cnt); end
    endtask

    task automatic test_data_change();
        logic [9:0] bits;
        logic [10:0] dones;
        arm();
        capture(8'hA3, 3, 8'hFF, bits, dones);
        checks++; if (bits !== 10'b0110001011) begin errors++; $display("FAIL data_change bits got %b want %b", bits, 10'b0110001011); end
        checks++; if (dones !== 11'b00000000001) begin errors++; $display("FAIL data_change done got %b want %b", dones, 11'b00000000001); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        logic [10:0] dones;
        int bad = 0;
        arm();
        data_a = 8'h00;
        send_a = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL reset_mid bit3 got %b want 0", tx_a); end
        rst = 1'b1;
        #1;
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_mid tx got %b want 1", tx_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_mid done got %b want 0", done_a); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (tx_a !== 1'b1 || done_a !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL reset_mid quiet got %0d want 0", bad); end
        arm();
        capture(8'h3C, -1, 8'h00, bits, dones);
        checks++; if (bits !== 10'b0001111001) begin errors++; $display("FAIL reset_mid frame bits got %b want %b", bits, 10'b0001111001); end
        checks++; if (dones !== 11'b00000000001) begin errors++; $display("FAIL reset_mid frame done got %b want %b", dones, 11'b00000000001); end
    endtask

    task automatic test_send_through_reset();
        logic [9:0] bits;
        logic [10:0] dones;
        int bad = 0;
        send_a = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx_a !== 1'b1 || done_a !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL send_thru_reset quiet got %0d want 0", bad); end
        arm();
        capture(8'h81, -1, 8'h00, bits, dones);
        checks++; if (bits !== 10'b0100000011) begin errors++; $display("FAIL send_thru_reset bits got %b want %b", bits, 10'b0100000011); end
        checks++; if (dones !== 11'b00000000001) begin errors++; $display("FAIL send_thru_reset done got %b want %b", dones, 11'b00000000001); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_send_held();
        test_slow();
        test_data_change();
        test_reset_mid();
        test_send_through_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
